// File: rtl/hilo_divider_pkg.sv
// Shared constants for the hi/lo divide unit.
// State encoding, divide-by-zero quotient and hi/lo read select.
package hilo_divider_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [DEF_WIDTH-1:0] DIV0_QUOTIENT = {DEF_WIDTH{1'b1}};

  localparam logic HILO_SEL_HI = 1'b1;
  localparam logic HILO_SEL_LO = 1'b0;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One restoring-division iteration on magnitudes.
// Purely combinational; the caller owns all state.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic           ge;

  // rem < divisor on entry, so the shifted value fits in WIDTH+1 bits
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, divisor});
    rem_nxt = ge ? WIDTH'(shifted - {1'b0, divisor})
                 : shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/hilo_divider.sv
// Iterative div/divu unit owning the hi/lo registers.
// Also accepts single-cycle mult writes and serves mfhi/mflo reads.
module hilo_divider
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic [WIDTH-1:0] wd0,
  input  logic [WIDTH-1:0] wd1,
  input  logic             ra,
  output logic [WIDTH-1:0] rd,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sgn_q, sgn_d;
  logic             a_neg_q, a_neg_d;
  logic             q_neg_q, q_neg_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             neg_rem;
  logic             neg_quo;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .divisor(dvsr_q),
    .rem_nxt(step_rem),
    .quo_nxt(step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    a_neg_d = a_neg_q;
    q_neg_d = q_neg_q;
    div0_d  = div0_q;
    neg_rem = sgn_q & a_neg_q;
    neg_quo = sgn_q & q_neg_q;
    case (state_q)
      ST_IDLE: begin
        if (we) begin
          hi_d = wd1;
          lo_d = wd0;
        end
        if (start) begin
          sgn_d   = is_signed;
          a_neg_d = a[WIDTH-1];
          q_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
          div0_d  = (b == '0);
          quo_d   = (is_signed && a[WIDTH-1]) ? -a : a;
          dvsr_d  = (is_signed && b[WIDTH-1]) ? -b : b;
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIN;
      end
      ST_FIN: begin
        // Zero divisor leaves |a| in rem; undoing the magnitude restores a
        hi_d = neg_rem ? -rem_q : rem_q;
        if (div0_q) begin
          lo_d = WIDTH'(DIV0_QUOTIENT);
        end else begin
          lo_d = neg_quo ? -quo_q : quo_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      a_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      a_neg_q <= a_neg_d;
      q_neg_q <= q_neg_d;
      div0_q  <= div0_d;
    end
  end

  assign rd   = (ra == HILO_SEL_HI) ? hi_q : lo_q;
  assign busy = (state_q == ST_RUN) || (state_q == ST_FIN);
  assign done = (state_q == ST_FIN);

endmodule

// File: tb/tb_hilo_divider.sv
// Directed and random checks of hilo_divider against an
// arithmetic reference model.
module tb_hilo_divider;

  logic        clk = 1'b0;
  logic        reset, start, is_signed, we, ra;
  logic [31:0] a, b, wd0, wd1, rd;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_divider dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_signed(is_signed),
    .a        (a),
    .b        (b),
    .we       (we),
    .wd0      (wd0),
    .wd1      (wd1),
    .ra       (ra),
    .rd       (rd),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {hi, lo} from the architectural definition of div/divu
  function automatic logic [63:0] model(input logic sgn,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    int sx, sy;
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (!sgn) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return {32'h0, 32'h8000_0000};
    sx = x;
    sy = y;
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    ra = 1'b1;
    #1;
    h = rd;
    ra = 1'b0;
    #1;
    l = rd;
  endtask

  task automatic issue(input logic sgn, input logic [31:0] av,
                       input logic [31:0] bv);
    start = 1'b1;
    is_signed = sgn;
    a = av;
    b = bv;
    tick();
    start = 1'b0;
  endtask

  // Called just after the accepting edge, or lat0 edges later
  task automatic wait_idle(input int lat0, output int lat, output int dones);
    lat = lat0;
    dones = 0;
    while (busy && lat < 60) begin
      if (done) dones++;
      tick();
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic sgn,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int lat, dones;
    logic [31:0] h, l;
    issue(sgn, av, bv);
    wait_idle(0, lat, dones);
    read_hilo(h, l);
    chk({tag, " latency"}, 32'(lat), 32'd33);
    chk({tag, " done"}, 32'(dones), 32'd1);
    chk({tag, " hi"}, h, exp_hi);
    chk({tag, " lo"}, l, exp_lo);
  endtask

  initial begin
    logic [31:0] h, l, av, bv;
    logic [63:0] m;
    logic        sgn;
    int          lat, dones;

    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    we = 1'b0;
    ra = 1'b0;
    a = '0;
    b = '0;
    wd0 = '0;
    wd1 = '0;
    tick();
    tick();
    reset = 1'b0;
    read_hilo(h, l);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hi", h, 32'h0);
    chk("reset lo", l, 32'h0);

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    run_div("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7,
            32'hFFFF_FFFE, 32'hFFFF_FFF2);
    run_div("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9,
            32'd2, 32'hFFFF_FFF2);
    run_div("divu by 0", 1'b0, 32'h1234_5678, 32'h0,
            32'h1234_5678, 32'hFFFF_FFFF);
    run_div("div by 0", 1'b1, 32'h1234_5678, 32'h0,
            32'h1234_5678, 32'hFFFF_FFFF);
    run_div("div neg by 0", 1'b1, 32'h8765_4321, 32'h0,
            32'h8765_4321, 32'hFFFF_FFFF);
    run_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0, 32'h8000_0000);

    we = 1'b1;
    wd0 = 32'hAAAA_0000;
    wd1 = 32'h0000_5555;
    tick();
    we = 1'b0;
    read_hilo(h, l);
    chk("mult hi", h, 32'h0000_5555);
    chk("mult lo", l, 32'hAAAA_0000);

    we = 1'b1;
    wd0 = 32'h1111_1111;
    wd1 = 32'h2222_2222;
    issue(1'b0, 32'd9, 32'd3);
    we = 1'b0;
    read_hilo(h, l);
    chk("mult+start busy", 32'(busy), 32'd1);
    chk("mult+start hi", h, 32'h2222_2222);
    chk("mult+start lo", l, 32'h1111_1111);
    wait_idle(0, lat, dones);
    read_hilo(h, l);
    chk("divu 9/3 latency", 32'(lat), 32'd33);
    chk("divu 9/3 hi", h, 32'd0);
    chk("divu 9/3 lo", l, 32'd3);

    issue(1'b0, 32'd200, 32'd9);
    tick();
    tick();
    tick();
    tick();
    start = 1'b1;
    a = 32'd5;
    b = 32'd1;
    we = 1'b1;
    wd0 = 32'hDEAD_BEEF;
    wd1 = 32'hCAFE_F00D;
    tick();
    start = 1'b0;
    we = 1'b0;
    read_hilo(h, l);
    chk("busy we hi", h, 32'd0);
    chk("busy we lo", l, 32'd3);
    wait_idle(5, lat, dones);
    read_hilo(h, l);
    chk("ignore latency", 32'(lat), 32'd33);
    chk("ignore done", 32'(dones), 32'd1);
    chk("ignore hi", h, 32'd2);
    chk("ignore lo", l, 32'd22);

    issue(1'b1, 32'hFFFF_FC18, 32'd3);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_hilo(h, l);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset done", 32'(done), 32'd0);
    chk("mid reset hi", h, 32'h0);
    chk("mid reset lo", l, 32'h0);
    run_div("after reset", 1'b0, 32'd1000, 32'd33, 32'd10, 32'd30);

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      av = $urandom;
      case ($urandom_range(0, 5))
        0: bv = 32'h0;
        1: bv = $urandom_range(1, 15);
        2: bv = -32'($urandom_range(1, 15));
        3: begin
          av = 32'h8000_0000;
          bv = 32'hFFFF_FFFF;
        end
        default: bv = $urandom;
      endcase
      m = model(sgn, av, bv);
      run_div($sformatf("rand%0d s%0d %h/%h", i, sgn, av, bv),
              sgn, av, bv, m[63:32], m[31:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
